// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe turn sequencer: cell marks,
// game result codes, sequencer states and small helper functions.
package ttt_pkg;

    // Number of cells on the board; legal cell indices are 0..NUM_CELLS-1.
    localparam int NUM_CELLS = 9;

    // Largest value the legal-move counter may reach in one game.
    localparam logic [3:0] MAX_MOVES = 4'(NUM_CELLS);

    // Mark written into a board cell.
    typedef enum logic [1:0] {
        MARK_EMPTY = 2'b00,
        MARK_PLYR  = 2'b01,
        MARK_COMP  = 2'b10
    } mark_e;

    // Game outcome reported on result.
    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_PLYR = 2'b01,
        RES_COMP = 2'b10,
        RES_DRAW = 2'b11
    } result_e;

    // Sequencer states, also exported on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // True when idx names an existing cell that is still empty.
    function automatic logic cell_is_free(input logic [NUM_CELLS-1:0] occ,
                                          input logic [3:0]           idx);
        logic [15:0] occ_ext;
        occ_ext = {{(16 - NUM_CELLS){1'b0}}, occ};
        return (idx < 4'(NUM_CELLS)) && !occ_ext[idx];
    endfunction

    // Move counter increment that holds at MAX_MOVES.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= MAX_MOVES) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/ttt_turn_timer.sv
// Turn timer: counts cycles while enabled and raises a combinational
// expiry flag in the cycle the count reaches TURN_TIMEOUT-1. The count
// restarts from zero after expiry or whenever clr_i is high.
// TURN_TIMEOUT = 0 disables the timer entirely (never expires).
module ttt_turn_timer #(
    parameter int TURN_TIMEOUT = 64,
    parameter int TMR_W        = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic             TMR_ON   = (TURN_TIMEOUT > 0);
    localparam logic [TMR_W-1:0] TMR_LAST = (TURN_TIMEOUT > 0) ? TMR_W'(TURN_TIMEOUT - 1) : '0;

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    assign expire_o = TMR_ON && en_i && !clr_i && (cnt_q == TMR_LAST);

    // Next count: clear wins, expiry wraps to zero, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i && TMR_ON) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe turn sequencer. Grants alternating turns to the player and
// the computer, validates each requested cell, issues one-cycle board
// writes, samples the win / board-full detectors after every write and
// ends the game. All outputs are registered.
//
// Handshake: a side's request is accepted in a cycle where its valid and
// its ready are both high at the rising edge. Ready is high only in WAIT
// and only for the side whose turn it is; the other side's valid is
// ignored. Valid may be raised at any time and is simply not consumed
// while ready is low.
module ttt_turn_sequencer
    import ttt_pkg::*;
#(
    parameter bit FIRST_MOVER  = 1'b0,
    parameter int TURN_TIMEOUT = 64,
    parameter int TMR_W        = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pl_valid,
    input  logic [3:0]           pl_pos,
    output logic                 pl_ready,
    input  logic                 pc_valid,
    input  logic [3:0]           pc_pos,
    output logic                 pc_ready,
    input  logic [NUM_CELLS-1:0] occ,
    input  logic                 win,
    input  logic [1:0]           who,
    input  logic                 no_space,
    output logic                 clr_board,
    output logic                 wr_en,
    output logic [3:0]           wr_idx,
    output logic [1:0]           wr_mark,
    output logic                 illegal,
    output logic                 timeout,
    output logic                 turn,
    output logic [3:0]           move_cnt,
    output logic                 game_over,
    output logic [1:0]           result,
    output logic [2:0]           dbg_state
);

    state_e     state_q, state_d;
    logic       turn_q, turn_d;
    logic       pl_ready_q, pl_ready_d;
    logic       pc_ready_q, pc_ready_d;
    logic       clr_board_q, clr_board_d;
    logic       wr_en_q, wr_en_d;
    logic [3:0] wr_idx_q, wr_idx_d;
    logic [1:0] wr_mark_q, wr_mark_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic [3:0] move_cnt_q, move_cnt_d;
    logic       game_over_q, game_over_d;
    logic [1:0] result_q, result_d;

    logic       req_fire;
    logic [3:0] req_pos;
    logic       req_legal;
    logic       tmr_en;
    logic       tmr_clr;
    logic       tmr_expire;

    // Request of the side holding the turn; the other side is never looked at.
    assign req_fire  = turn_q ? (pc_valid && pc_ready_q) : (pl_valid && pl_ready_q);
    assign req_pos   = turn_q ? pc_pos : pl_pos;
    assign req_legal = cell_is_free(occ, req_pos);

    // The timer only runs while a side holds the turn.
    assign tmr_en  = (state_q == ST_WAIT);
    assign tmr_clr = (state_q != ST_WAIT);

    ttt_turn_timer #(
        .TURN_TIMEOUT (TURN_TIMEOUT),
        .TMR_W        (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        turn_d      = turn_q;
        move_cnt_d  = move_cnt_q;
        result_d    = result_q;
        game_over_d = game_over_q;
        clr_board_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_idx_d    = 4'd0;
        wr_mark_d   = MARK_EMPTY;
        illegal_d   = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_WAIT;
                    clr_board_d = 1'b1;
                    move_cnt_d  = 4'd0;
                    result_d    = RES_NONE;
                    game_over_d = 1'b0;
                    turn_d      = FIRST_MOVER;
                end
            end

            ST_WAIT: begin
                if (req_fire && req_legal) begin
                    // A legal accept beats a simultaneous timer expiry.
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    wr_idx_d  = req_pos;
                    wr_mark_d = turn_q ? MARK_COMP : MARK_PLYR;
                end else begin
                    if (req_fire) begin
                        illegal_d = 1'b1;
                    end
                    if (tmr_expire) begin
                        timeout_d = 1'b1;
                        turn_d    = ~turn_q;
                    end
                end
            end

            ST_WRITE: begin
                state_d    = ST_CHECK;
                move_cnt_d = sat_inc(move_cnt_q);
            end

            ST_CHECK: begin
                // Win is examined first so a winning final move is not a draw.
                if (win) begin
                    state_d     = ST_OVER;
                    result_d    = who;
                    game_over_d = 1'b1;
                end else if (no_space) begin
                    state_d     = ST_OVER;
                    result_d    = RES_DRAW;
                    game_over_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    turn_d  = ~turn_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pl_ready_d = (state_d == ST_WAIT) && !turn_d;
        pc_ready_d = (state_d == ST_WAIT) &&  turn_d;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output registers; reset clears everything, dropping any write in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turn_q      <= 1'b0;
            pl_ready_q  <= 1'b0;
            pc_ready_q  <= 1'b0;
            clr_board_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_idx_q    <= 4'd0;
            wr_mark_q   <= 2'b00;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            move_cnt_q  <= 4'd0;
            game_over_q <= 1'b0;
            result_q    <= 2'b00;
        end else begin
            turn_q      <= turn_d;
            pl_ready_q  <= pl_ready_d;
            pc_ready_q  <= pc_ready_d;
            clr_board_q <= clr_board_d;
            wr_en_q     <= wr_en_d;
            wr_idx_q    <= wr_idx_d;
            wr_mark_q   <= wr_mark_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            move_cnt_q  <= move_cnt_d;
            game_over_q <= game_over_d;
            result_q    <= result_d;
        end
    end

    assign pl_ready  = pl_ready_q;
    assign pc_ready  = pc_ready_q;
    assign clr_board = clr_board_q;
    assign wr_en     = wr_en_q;
    assign wr_idx    = wr_idx_q;
    assign wr_mark   = wr_mark_q;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign turn      = turn_q;
    assign move_cnt  = move_cnt_q;
    assign game_over = game_over_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Directed bench for ttt_turn_sequencer. Surrounds the sequencer with a
// board register file and win / board-full detectors, plays several
// scripted games and compares outputs against hand-computed values.
module tb_ttt_turn_sequencer;
    import ttt_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pl_valid;
    logic [3:0] pl_pos;
    logic       pl_ready;
    logic       pc_valid;
    logic [3:0] pc_pos;
    logic       pc_ready;
    logic [8:0] occ;
    logic       win;
    logic [1:0] who;
    logic       no_space;
    logic       clr_board;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [1:0] wr_mark;
    logic       illegal;
    logic       timeout;
    logic       turn;
    logic [3:0] move_cnt;
    logic       game_over;
    logic [1:0] result;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected board writes as {idx, mark}, in issue order.
    logic [5:0] exp_q[$];

    logic [8:0][1:0] board = '0;

    localparam int LINES [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

    // Clock.
    always #5 clk = ~clk;

    ttt_turn_sequencer #(
        .FIRST_MOVER  (1'b0),
        .TURN_TIMEOUT (64),
        .TMR_W        (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pl_valid  (pl_valid),
        .pl_pos    (pl_pos),
        .pl_ready  (pl_ready),
        .pc_valid  (pc_valid),
        .pc_pos    (pc_pos),
        .pc_ready  (pc_ready),
        .occ       (occ),
        .win       (win),
        .who       (who),
        .no_space  (no_space),
        .clr_board (clr_board),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_mark   (wr_mark),
        .illegal   (illegal),
        .timeout   (timeout),
        .turn      (turn),
        .move_cnt  (move_cnt),
        .game_over (game_over),
        .result    (result),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] find_winner(input logic [8:0][1:0] b);
        logic [1:0] w;
        w = 2'b00;
        for (int k = 0; k < 8; k++) begin
            if (b[LINES[3*k]] != 2'b00 &&
                b[LINES[3*k]] == b[LINES[3*k+1]] &&
                b[LINES[3*k]] == b[LINES[3*k+2]]) begin
                w = b[LINES[3*k]];
            end
        end
        return w;
    endfunction

    // Board register file written by the sequencer.
    always @(posedge clk) begin
        if (clr_board) begin
            board <= '0;
        end else if (wr_en && wr_idx < 4'd9) begin
            board[wr_idx] <= wr_mark;
        end
    end

    // Winner and board-full detectors.
    always_comb begin
        occ = '0;
        for (int i = 0; i < 9; i++) begin
            occ[i] = (board[i] != 2'b00);
        end
        who      = find_winner(board);
        win      = (who != 2'b00);
        no_space = &occ;
    end

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", exp_q.size(), 1);
            end else begin
                check("wr_txn", {26'd0, wr_idx, wr_mark}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    // Pulse start from IDLE/OVER and check the new-game state.
    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_clr", clr_board, 1);
        check("start_cnt", move_cnt, 0);
        check("start_result", result, 0);
        check("start_turn", turn, 0);
        check("start_pl_ready", pl_ready, 1);
        check("start_over", game_over, 0);
        @(negedge clk);
        check("clr_pulse_len", clr_board, 0);
    endtask

    // Present one request from a side and check the accept or reject response.
    task automatic do_move(input logic side, input logic [3:0] pos, input logic legal);
        int w;
        w = 0;
        while (((side == 1'b0) ? pl_ready : pc_ready) !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", (w < 8), 1);
        if (side == 1'b0) begin
            pl_valid = 1'b1;
            pl_pos   = pos;
        end else begin
            pc_valid = 1'b1;
            pc_pos   = pos;
        end
        if (legal) exp_q.push_back({pos, (side ? 2'b10 : 2'b01)});
        @(negedge clk);
        pl_valid = 1'b0;
        pc_valid = 1'b0;
        if (legal) begin
            check("acc_wr_en", wr_en, 1);
            check("acc_ready_low", {pl_ready, pc_ready}, 0);
            @(negedge clk);
            check("chk_state", dbg_state, ST_CHECK);
            check("chk_not_over", game_over, 0);
            @(negedge clk);
        end else begin
            check("ill_pulse", illegal, 1);
            check("ill_no_wr", wr_en, 0);
            check("ill_turn", turn, side);
            @(negedge clk);
            check("ill_pulse_len", illegal, 0);
        end
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion by 200000");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        pl_valid = 1'b0;
        pl_pos   = 4'd0;
        pc_valid = 1'b0;
        pc_pos   = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_turn", turn, 0);
        check("rst_result", result, 0);
        check("rst_cnt", move_cnt, 0);
        check("rst_over", game_over, 0);
        check("rst_ready", {pl_ready, pc_ready}, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_clr", clr_board, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_hold", dbg_state, ST_IDLE);

        // Game 1: scripted draw with ignored, illegal and mid-game start requests.
        start_game();
        do_move(1'b0, 4'd4, 1'b1);
        check("g1_turn_c", turn, 1);
        check("g1_pc_ready", pc_ready, 1);
        check("g1_pl_ready", pl_ready, 0);
        do_move(1'b1, 4'd0, 1'b1);
        check("g1_cnt2", move_cnt, 2);
        check("g1_turn_p", turn, 0);

        pc_valid = 1'b1;
        pc_pos   = 4'd8;
        repeat (3) begin
            @(negedge clk);
            check("ign_pc_ready", pc_ready, 0);
            check("ign_wr", wr_en, 0);
            check("ign_state", dbg_state, ST_WAIT);
        end
        pc_valid = 1'b0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_clr", clr_board, 0);
        check("mid_start_cnt", move_cnt, 2);

        do_move(1'b0, 4'd4, 1'b0);
        do_move(1'b0, 4'd12, 1'b0);
        do_move(1'b0, 4'd5, 1'b1);
        do_move(1'b1, 4'd3, 1'b1);
        do_move(1'b0, 4'd6, 1'b1);
        do_move(1'b1, 4'd2, 1'b1);
        do_move(1'b0, 4'd1, 1'b1);
        do_move(1'b1, 4'd7, 1'b1);
        do_move(1'b0, 4'd8, 1'b1);
        check("draw_result", result, 3);
        check("draw_over", game_over, 1);
        check("draw_cnt", move_cnt, 9);
        check("draw_ready", {pl_ready, pc_ready}, 0);
        check("draw_state", dbg_state, ST_OVER);

        // Game 2: player forfeits by timeout, then player wins row 0.
        start_game();
        n = 0;
        while (timeout !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_lat", n, 63);
        check("timeout_turn", turn, 1);
        check("timeout_pc_ready", pc_ready, 1);
        check("timeout_pl_ready", pl_ready, 0);
        @(negedge clk);
        check("timeout_len", timeout, 0);
        do_move(1'b1, 4'd3, 1'b1);
        do_move(1'b0, 4'd0, 1'b1);
        do_move(1'b1, 4'd4, 1'b1);
        do_move(1'b0, 4'd1, 1'b1);
        do_move(1'b1, 4'd8, 1'b1);
        do_move(1'b0, 4'd2, 1'b1);
        check("win_result", result, 1);
        check("win_over", game_over, 1);
        check("win_ready", {pl_ready, pc_ready}, 0);
        check("win_cnt", move_cnt, 6);

        // Game 3: ninth move completes a line on a full board.
        start_game();
        do_move(1'b0, 4'd5, 1'b1);
        do_move(1'b1, 4'd3, 1'b1);
        do_move(1'b0, 4'd6, 1'b1);
        do_move(1'b1, 4'd4, 1'b1);
        do_move(1'b0, 4'd0, 1'b1);
        do_move(1'b1, 4'd7, 1'b1);
        do_move(1'b0, 4'd2, 1'b1);
        do_move(1'b1, 4'd8, 1'b1);
        do_move(1'b0, 4'd1, 1'b1);
        check("win9_result", result, 1);
        check("win9_cnt", move_cnt, 9);
        check("win9_over", game_over, 1);

        // Game 4: reset lands in the middle of a computer write.
        start_game();
        do_move(1'b0, 4'd4, 1'b1);
        pc_valid = 1'b1;
        pc_pos   = 4'd0;
        exp_q.push_back({4'd0, 2'b10});
        @(negedge clk);
        pc_valid = 1'b0;
        check("rw_wr_en", wr_en, 1);
        check("rw_cnt_before", move_cnt, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rw_wr_en_rst", wr_en, 0);
        check("rw_wr_idx_rst", wr_idx, 0);
        check("rw_wr_mark_rst", wr_mark, 0);
        check("rw_state_rst", dbg_state, ST_IDLE);
        check("rw_cnt_rst", move_cnt, 0);
        check("rw_turn_rst", turn, 0);
        check("rw_ready_rst", {pl_ready, pc_ready}, 0);
        @(posedge clk);
        #1;
        check("rw_dropped", board[0], 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_game();

        check("wr_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
